// File: rtl/cache_fill_if.sv
// cache_fill_if: bundles the miss request, memory read/return and cache
// array write signals of the cache fill controller.
// master = the fill controller; slave = the CPU/cache/memory side.
interface cache_fill_if #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [OFF_W-1:0]  fill_word_offset;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_rd_en, memory_address, write_data_array,
           fill_word_offset, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_rd_en, memory_address, write_data_array,
           fill_word_offset, fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, fetches the whole block from pipelined
// memory (one request per cycle), writes each returned word into the data
// array and pulses the tag write together with the last word.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN: start the fill at the missed
// word and wrap around the block instead of starting at word 0.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_block_base;
  logic [OFF_W-1:0]  r_start_off;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;

  logic              w_accept;
  logic              w_issue;
  logic              w_ret;
  logic              w_last;
  logic [ADDR_W-1:0] w_miss_base;
  logic [OFF_W-1:0]  w_miss_off;
  logic [OFF_W-1:0]  w_issue_off;
  logic [OFF_W-1:0]  w_ret_off;
  logic              w_unused_addr_lo;

  logic              w_fsm_busy;
  logic              w_mem_rd_en;
  logic [ADDR_W-1:0] w_memory_address;
  logic              w_write_data_array;
  logic [OFF_W-1:0]  w_fill_word_offset;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_write_tag_array;

  // Block base: clear the word-offset bits plus the byte-in-word bit.
  assign w_miss_base = {bus.miss_address[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign w_miss_off = bus.miss_address[OFF_W:1];
`else
  assign w_miss_off = '0;
`endif
  // Byte-in-word bit (and offset bits when fill is block-aligned) are don't-care.
  assign w_unused_addr_lo = ^bus.miss_address[OFF_W:0];

  assign w_accept = (r_state == S_IDLE) && bus.miss_detected;
  assign w_issue  = (r_state == S_FILL) && (r_issue_cnt < FULL_CNT);
  assign w_ret    = (r_state == S_FILL) && bus.memory_data_valid;
  assign w_last   = w_ret && (r_ret_cnt == LAST_CNT);

  // Offsets wrap naturally because the sums are OFF_W bits wide.
  assign w_issue_off = r_start_off + r_issue_cnt[OFF_W-1:0];
  assign w_ret_off   = r_start_off + r_ret_cnt[OFF_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fill bookkeeping: latch block on miss acceptance, count issues and returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_block_base <= '0;
      r_start_off  <= '0;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
    end else if (w_accept) begin
      r_block_base <= w_miss_base;
      r_start_off  <= w_miss_off;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_ret) begin
        r_ret_cnt <= r_ret_cnt + 1'b1;
      end
    end
  end

  // Next state: start a fill on a miss, finish after the last returned word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.miss_detected) w_state_next = S_FILL;
      S_FILL:  if (w_last)            w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: purely combinational from state, counters and the return strobe.
  always_comb begin
    w_fsm_busy         = 1'b0;
    w_mem_rd_en        = 1'b0;
    w_memory_address   = '0;
    w_write_data_array = 1'b0;
    w_fill_word_offset = '0;
    w_fill_data        = '0;
    w_write_tag_array  = 1'b0;
    if (r_state == S_FILL) begin
      w_fsm_busy = 1'b1;
      if (w_issue) begin
        w_mem_rd_en      = 1'b1;
        w_memory_address = r_block_base + ADDR_W'({w_issue_off, 1'b0});
      end
      if (w_ret) begin
        w_write_data_array = 1'b1;
        w_fill_word_offset = w_ret_off;
        w_fill_data        = bus.memory_data;
        w_write_tag_array  = w_last;
      end
    end
  end

  assign bus.fsm_busy         = w_fsm_busy;
  assign bus.mem_rd_en        = w_mem_rd_en;
  assign bus.memory_address   = w_memory_address;
  assign bus.write_data_array = w_write_data_array;
  assign bus.fill_word_offset = w_fill_word_offset;
  assign bus.fill_data        = w_fill_data;
  assign bus.write_tag_array  = w_write_tag_array;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: drives misses and a pipelined memory with configurable
// latency, gaps and random stalls; compares every cycle against a queue-based
// model of the expected request addresses and write offsets.
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) bus ();

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit          exp_busy = 0;
  logic [15:0] addr_q[$];
  logic [2:0]  off_q[$];
  int          mem_q[$];      // cycle at which each issued request may return
  int          cyc = 0;
  int          n_ret = 0;
  int          busy_cycles = 0;

  // Scenario knobs.
  int          cur_lat = 0;
  int          gap_at = -1;
  int          gap_left = 0;
  int          rst_at = -1;
  bit          rst_req = 0;
  bit          rnd_stall = 0;
  bit          idle_valid = 0;
  bit          miss_pending = 0;
  logic [15:0] miss_addr_v = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, bus.fsm_busy, 0);
    check({pfx, "_rd_en"}, bus.mem_rd_en, 0);
    check({pfx, "_addr"}, bus.memory_address, 0);
    check({pfx, "_wr"}, bus.write_data_array, 0);
    check({pfx, "_off"}, bus.fill_word_offset, 0);
    check({pfx, "_data"}, bus.fill_data, 0);
    check({pfx, "_tag"}, bus.write_tag_array, 0);
  endtask

  task automatic do_reset();
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    bus.miss_detected     = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    exp_busy = 0;
    addr_q.delete();
    off_q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    bit          acc;
    bit          drv_valid;
    bit          exp_rd;
    bit          exp_wr;
    bit          exp_tag;
    logic [15:0] d;
    int          s;
    logic [15:0] base;
    if (rst_req) begin
      do_reset();
      rst_req = 0;
    end
    acc = 0;
    d = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'($urandom);
    if (miss_pending && !exp_busy) begin
      bus.miss_detected = 1'b1;
      bus.miss_address  = miss_addr_v;
      acc = 1;
      miss_pending = 0;
    end else if (exp_busy && $urandom_range(3) == 0) begin
      bus.miss_detected = 1'b1;   // must be ignored during a fill
    end
    #1;
    if (bus.mem_rd_en) mem_q.push_back(cyc + cur_lat);
    drv_valid = 0;
    if (mem_q.size() > 0 && mem_q[0] <= cyc) begin
      if (exp_busy && n_ret == gap_at && gap_left > 0) gap_left--;
      else if (rnd_stall && $urandom_range(2) == 0) drv_valid = 0;
      else begin
        drv_valid = 1;
        void'(mem_q.pop_front());
      end
    end else if (idle_valid && !exp_busy) begin
      drv_valid = 1;
    end
    if (drv_valid) begin
      d = 16'($urandom);
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = d;
    end
    #1;
    exp_rd  = exp_busy && (addr_q.size() > 0);
    exp_wr  = exp_busy && drv_valid;
    exp_tag = exp_wr && (off_q.size() == 1);
    check("busy", bus.fsm_busy, exp_busy);
    check("rd_en", bus.mem_rd_en, exp_rd);
    check("addr", bus.memory_address, exp_rd ? addr_q[0] : 16'h0);
    check("wr", bus.write_data_array, exp_wr);
    check("off", bus.fill_word_offset, exp_wr ? off_q[0] : 3'd0);
    check("data", bus.fill_data, exp_wr ? d : 16'h0);
    check("tag", bus.write_tag_array, exp_tag);
    if (bus.fsm_busy) busy_cycles++;
    if (exp_rd) void'(addr_q.pop_front());
    if (exp_wr) begin
      void'(off_q.pop_front());
      n_ret++;
      if (off_q.size() == 0) exp_busy = 0;
    end
    if (acc) begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      s = int'(miss_addr_v[3:1]);
`else
      s = 0;
`endif
      base = miss_addr_v & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
        addr_q.push_back(base + 16'(2 * ((s + k) % 8)));
        off_q.push_back(3'((s + k) % 8));
      end
      exp_busy = 1;
      n_ret = 0;
    end
    if (rst_at >= 0 && exp_busy && n_ret == rst_at) begin
      rst_req = 1;
      rst_at = -1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_fill(input logic [15:0] addr, input int lat, input int g_at,
                          input int g_len, input int r_at, input bit stall);
    int guard;
    int rst_cfg;
    bit pending;
    cur_lat = lat;
    gap_at = g_at;
    gap_left = g_len;
    rst_at = r_at;
    rst_cfg = r_at;
    rnd_stall = stall;
    busy_cycles = 0;
    miss_addr_v = addr;
    miss_pending = 1;
    guard = 0;
    do begin
      step();
      guard++;
    end while ((exp_busy || miss_pending || rst_req || mem_q.size() > 0) && guard < 400);
    pending = exp_busy || miss_pending || (mem_q.size() > 0);
    check("fill_done", pending, 0);
    if (lat == 0 && g_at < 0 && r_at < 0 && !stall) check("busy_len", busy_cycles, 8);
    step();
    $display("fill addr=%04h lat=%0d gap_at=%0d gap_len=%0d rst_at=%0d stall=%0d busy_cycles=%0d",
             addr, lat, g_at, g_len, rst_cfg, stall, busy_cycles);
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    idle_valid = 1;
    for (int i = 0; i < 3; i++) step();
    idle_valid = 0;
    $display("idle with stray memory_data_valid: cycles=3");

    run_fill(16'h1234, 4, -1, 0, -1, 0);   // basic, latency 4
    run_fill(16'h1234, 0, -1, 0, -1, 0);   // zero-latency memory
    run_fill(16'h5678, 2, 4, 3, -1, 0);    // 3-cycle gap after 4th word
    run_fill(16'hABCD, 3, -1, 0, 5, 0);    // reset after 5th word
    run_fill(16'h00F2, 1, -1, 0, -1, 0);
    run_fill(16'h1236, 2, -1, 0, -1, 0);   // critical-word case
    run_fill(16'hFFFE, 0, -1, 0, -1, 0);   // top of address space

    for (int i = 0; i < 20; i++) begin
      run_fill(16'($urandom), int'($urandom_range(6)),
               ($urandom_range(1) == 1) ? int'($urandom_range(7, 1)) : -1,
               int'($urandom_range(4)), -1, 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's cache (I or D) and the multi-cycle, pipelined main memory.
- On a cache miss, it fetches the full 8-word (16-byte) block from memory and writes each returned word into the cache data array.
- It then writes the tag array and releases the stall.
- It sits directly downstream of the CPU datapath, replacing the CPU's direct single-cycle memory access.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; must be a power of 2; word offset width = log2(WORDS_PER_BLOCK).
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- miss_detected  input  1  cache miss for miss_address; sampled only in IDLE.
- miss_address  input  ADDR_W  byte address that missed.
- memory_data_valid  input  1  memory returns one word this cycle; words arrive in request order.
- memory_data  input  DATA_W  returned word, valid with memory_data_valid.
- fsm_busy  output  1  high while a fill is in progress; the CPU stalls on it.
- mem_rd_en  output  1  read request to memory this cycle.
- memory_address  output  ADDR_W  byte address of the current request.
- write_data_array  output  1  write fill_data at fill_word_offset this cycle.
- fill_word_offset  output  log2(WORDS_PER_BLOCK)  word index within block for the current write.
- fill_data  output  DATA_W  word to write; equals memory_data.
- write_tag_array  output  1  one-cycle pulse to write the tag and set the valid bit.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; block_base, start_off, issue_cnt and ret_cnt all 0.
  - All outputs 0.
- Block base: block_base = miss_address with low log2(WORDS_PER_BLOCK)+1 bits cleared (byte addressing, 2 bytes/word). For the default, addr & 16'hFFF0.
- State IDLE:
  - fsm_busy=0, mem_rd_en=0, write_data_array=0, write_tag_array=0.
  - memory_data_valid is ignored.
  - On miss_detected=1: latch block_base, set start_off (0 unless the optional feature is on), clear both counters, go to FILL next cycle.
- State FILL, fsm_busy=1. Request issue and data return are independent and may overlap.
  - Issue side:
    - While issue_cnt < WORDS_PER_BLOCK: mem_rd_en=1, memory_address = block_base + 2*((start_off+issue_cnt) mod WORDS_PER_BLOCK), issue_cnt++ each cycle.
    - One request per cycle, no backpressure.
    - When issue_cnt reaches WORDS_PER_BLOCK: mem_rd_en=0, memory_address=0.
  - Return side:
    - Each cycle with memory_data_valid=1: write_data_array=1, fill_word_offset=(start_off+ret_cnt) mod WORDS_PER_BLOCK, fill_data=memory_data, ret_cnt++.
    - Outputs are combinational from the counters, state and memory_data_valid: zero added latency.
  - Completion:
    - On the cycle the WORDS_PER_BLOCK-th valid word arrives: write_tag_array=1 in that same cycle, with write_data_array=1.
    - Next cycle: state=IDLE, fsm_busy=0.
  - miss_detected during FILL is ignored; a new miss is accepted no earlier than the cycle after returning to IDLE.
  - memory_data_valid arriving before any request has been issued is a memory protocol error. It is not guarded, and the bench must not drive it.
- Latency: a full fill takes memory latency + WORDS_PER_BLOCK cycles from the first request. Minimum fsm_busy duration is WORDS_PER_BLOCK cycles (zero-latency memory).
- Reset mid-fill: immediate return to IDLE; any outstanding memory responses after reset are ignored, since they arrive while in IDLE.
- Arithmetic: address computation wraps modulo 2^ADDR_W; offsets wrap modulo WORDS_PER_BLOCK.

Optional Feature:
- Macro CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - On miss acceptance, start_off = miss_address[log2(WORDS_PER_BLOCK):1].
  - Requests and writes begin at the missed word and wrap around the block. For example, a miss at 16'h1236 requests 1236, 1238, 123A, 123C, 123E, 1230, 1232, 1234.
  - First write offset is 3.
- Undefined: start_off is always 0; fill is in ascending order from block_base.

Test Plan:
- Reset then idle: assert rst for 2 cycles with miss_detected=0 -> all outputs 0; memory_data_valid=1 in IDLE causes no write.
- Basic fill, memory latency 4: miss at 16'h1234 ->
  - fsm_busy rises the next cycle.
  - mem_rd_en high for 8 cycles with addresses 1230..123E step 2.
  - 8 write_data_array pulses at offsets 0..7 carrying memory data D0..D7.
  - write_tag_array coincides with the 8th write.
  - fsm_busy drops the following cycle.
- Zero-latency memory (valid in the same cycle as each request) -> fsm_busy high for exactly 8 cycles; write and issue overlap each cycle.
- Gapped returns: insert 3 idle cycles between the 4th and 5th valid -> write_tag_array only on the 8th valid; fsm_busy stays high across the gap.
- Reset mid-fill: assert rst after the 5th valid word -> immediate IDLE with outputs 0. A subsequent miss at 16'h00F2 fills 00F0..00FE from offset 0.
- With CACHE_CRITICAL_WORD_FIRST_EN: miss at 16'h1236 ->
  - Addresses 1236, 1238, 123A, 123C, 123E, 1230, 1232, 1234.
  - Write offsets 3, 4, 5, 6, 7, 0, 1, 2.
  - Tag write on the 8th.
